// File: rtl/bt_uart_pkg.sv
// Shared types and helpers for the Bluetooth-link UART receiver.
package bt_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clock cycles per oversample tick
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/bt_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1, pulses tick on the last count, sync clear.
module bt_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // tick is registered so that it is high exactly while cnt == DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/bt_uart_rx.sv
// UART receiver: 2-FF synchroniser, oversampled 3-sample majority vote, false-start rejection,
// registered output word with valid/ready handshake and frame/parity/overrun flags.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9_600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned S_W  = $clog2(OVERSAMPLE);
    localparam int unsigned M    = OVERSAMPLE / 2;
    localparam int unsigned BC_W = 4;

    if (DIV < 2) begin : g_bad_div
        $error("bt_uart_rx: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("bt_uart_rx: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("bt_uart_rx: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_par
        $error("bt_uart_rx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("bt_uart_rx: STOP_BITS must be 1 or 2");
    end

    logic [1:0] sync_q;
    logic       rxd_s;

    rx_state_t            state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [BC_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           smp_q, smp_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;

    logic tick, tick_clr_c;
    logic last_s_c, at_res_c, at_end_c, vote_c;
    logic done_c, done_ferr_c;

    // Line synchroniser, preset to idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], RxD};
    end
    assign rxd_s = sync_q[1];

    assign tick_clr_c = (state_q == ST_IDLE) && (state_d != ST_IDLE);

    bt_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr_c),
        .tick  (tick)
    );

    assign last_s_c = (s_q == S_W'(OVERSAMPLE - 1));
    assign at_res_c = tick && (s_q == S_W'(M + 1));
    assign at_end_c = tick && last_s_c;
    assign vote_c   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        smp_d       = smp_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        armed_d     = armed_q;
        done_c      = 1'b0;
        done_ferr_c = 1'b0;

        // Sample index and the two early vote samples, common to all bit states
        if (state_q != ST_IDLE && tick) begin
            s_d = last_s_c ? '0 : s_q + S_W'(1);
            if (s_q == S_W'(M - 1)) smp_d[0] = rxd_s;
            if (s_q == S_W'(M))     smp_d[1] = rxd_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (rxd_s) armed_d = 1'b1;
                if (tick && armed_q && !rxd_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (at_res_c && vote_c) begin
                    state_d = ST_IDLE;
                end else if (at_end_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_res_c) shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
                if (at_end_c) begin
                    if (bit_q == BC_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (at_res_c) begin
                    perr_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ vote_c) : (^shift_q ^ vote_c);
                end
                if (at_end_c) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (at_res_c) begin
                    if (!vote_c) ferr_d = 1'b1;
                    // Leave at the last resolve; a low line here must go high before re-arming
                    if (bit_q == BC_W'(STOP_BITS - 1)) begin
                        state_d     = ST_IDLE;
                        armed_d     = vote_c;
                        done_c      = 1'b1;
                        done_ferr_c = ferr_q | ~vote_c;
                    end
                end else if (at_end_c) begin
                    bit_d = bit_q + BC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output word register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RxData     <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            if (done_c) begin
                if (!rx_valid || rx_ready) begin
                    RxData     <= shift_q;
                    frame_err  <= done_ferr_c;
                    parity_err <= perr_q;
                    overrun    <= 1'b0;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Scoreboard bench for bt_uart_rx: an 8N1 and an 8E1 instance driven by a frame-level line model.
module tb_bt_uart_rx;

    localparam int unsigned BIT_CLK = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0, data1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    bt_uart_rx #(.CLK_FREQ(1_536_000), .BAUD_RATE(9_600), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rx_8n1 (
        .clk(clk), .rst_n(rst_n), .RxD(rxd0), .RxData(data0), .rx_valid(v0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0)
    );

    bt_uart_rx #(.CLK_FREQ(1_536_000), .BAUD_RATE(9_600), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_rx_8e1 (
        .clk(clk), .rst_n(rst_n), .RxD(rxd1), .RxData(data1), .rx_valid(v1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   acc0 = 1'b0, acc1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor step: pops the scoreboard on every accepted word
    task automatic mon_step(input int idx, input logic v, input logic rdy, input logic [7:0] d,
                            input logic fe, input logic pe, input logic ov,
                            input bit prev, output bit acc);
        exp_t e;
        if (prev) chk($sformatf("rx%0d_valid_drop", idx), 32'(v), 0);
        acc = 1'b0;
        if (v && rdy) begin
            acc = 1'b1;
            if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx%0d_unexpected: got word %0h, expected no word", idx, d);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rx%0d_data", idx), 32'(d), 32'(e.data));
                chk($sformatf("rx%0d_frame_err", idx), 32'(fe), 32'(e.ferr));
                chk($sformatf("rx%0d_parity_err", idx), 32'(pe), 32'(e.perr));
                chk($sformatf("rx%0d_overrun", idx), 32'(ov), 32'(e.ovr));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) acc0 = 1'b0;
        else        mon_step(0, v0, rdy0, data0, fe0, pe0, ov0, acc0, acc0);
    end

    always @(negedge clk) begin
        if (!rst_n) acc1 = 1'b0;
        else        mon_step(1, v1, rdy1, data1, fe1, pe1, ov1, acc1, acc1);
    end

    task automatic drive(input int idx, input logic val, input int unsigned n);
        if (idx == 0) rxd0 = val;
        else          rxd1 = val;
        repeat (n) @(posedge clk);
    endtask

    // Line model: start, 8 data LSB first, even parity bit on instance 1, one stop bit
    task automatic send(input int idx, input logic [7:0] d, input logic pbit,
                        input logic stopv, input logic ovr, input bit push);
        exp_t e;
        logic [7:0] dv;
        dv     = d;
        e.data = d;
        e.ferr = ~stopv;
        e.perr = (idx == 1) ? ((^d) ^ pbit) : 1'b0;
        e.ovr  = ovr;
        if (push) begin
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        drive(idx, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(idx, dv[i], BIT_CLK);
        if (idx == 1) drive(idx, pbit, BIT_CLK);
        drive(idx, stopv, BIT_CLK);
        drive(idx, 1'b1, 0);
    endtask

    task automatic wait_drain(input int idx, input int unsigned budget);
        int unsigned t;
        t = 0;
        while (t < budget && ((idx == 0) ? (q0.size() != 0 || b0 || v0)
                                         : (q1.size() != 0 || b1 || v1))) begin
            @(posedge clk);
            t++;
        end
        chk($sformatf("rx%0d_drain_timeout", idx), 32'(t >= budget), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data0"}, 32'(data0), 0);
        chk({tag, "_flags0"}, {27'd0, v0, fe0, pe0, ov0, b0}, 0);
        chk({tag, "_data1"}, 32'(data1), 0);
        chk({tag, "_flags1"}, {27'd0, v1, fe1, pe1, ov1, b1}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [7:0]  d;
        logic        pbit, stopv;
        int unsigned gap;

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Basic 8N1 word
        send(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain(0, 400);

        // Even parity with both parity bit values
        send(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1, 1'b1, BIT_CLK);
        send(1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain(1, 400);

        // Stop bit low, then a break held well past one frame
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, BIT_CLK);
        wait_drain(0, 400);
        q0.push_back('{data: 8'h00, ferr: 1'b1, perr: 1'b0, ovr: 1'b0});
        drive(0, 1'b0, BIT_CLK * 18);
        chk("break_single_word", 32'(q0.size()), 0);
        drive(0, 1'b1, BIT_CLK);
        send(0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain(0, 400);

        // 40-clk glitch on idle line
        seen = 1'b0;
        rxd0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen |= b0;
        end
        rxd0 = 1'b1;
        for (int i = 0; i < int'(BIT_CLK); i++) begin
            @(posedge clk);
            #1;
            seen |= b0;
        end
        chk("glitch_busy_seen", 32'(seen), 1);
        chk("glitch_busy_clear", 32'(b0), 0);
        chk("glitch_no_valid", 32'(v0), 0);

        // Overrun while the consumer stalls
        rdy0 = 1'b0;
        send(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_held_valid", 32'(v0), 1);
        chk("ovr_held_data", 32'(data0), 32'h11);
        chk("ovr_flag", 32'(ov0), 1);
        rdy0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("ovr_valid_cleared", 32'(v0), 0);
        chk("ovr_flag_cleared", 32'(ov0), 0);
        wait_drain(0, 400);

        // Reset mid-frame: start bit and three data bits of 0x3C, then reset
        drive(0, 1'b0, BIT_CLK);
        drive(0, 1'b0, BIT_CLK);
        drive(0, 1'b0, BIT_CLK);
        drive(0, 1'b1, BIT_CLK / 2);
        chk("mid_frame_busy", 32'(b0), 1);
        #1;
        rst_n = 1'b0;
        rxd0  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        repeat (BIT_CLK * 2) @(posedge clk);
        send(0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain(0, 400);

        // Random frames on both instances
        for (int k = 0; k < 20; k++) begin
            d     = 8'($urandom);
            pbit  = 1'($urandom);
            stopv = ($urandom_range(0, 3) != 0);
            send(k % 2, d, pbit, stopv, 1'b0, 1'b1);
            gap = stopv ? $urandom_range(0, 2) * (BIT_CLK / 2) : BIT_CLK + $urandom_range(0, 40);
            drive(k % 2, 1'b1, gap);
        end
        wait_drain(0, 400);
        wait_drain(1, 400);
        chk("q0_empty", 32'(q0.size()), 0);
        chk("q1_empty", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
